// File: rtl/demux_tdm_1xn_pkg.sv
// Purpose  : shared types and constants for the TDM 1xN demultiplexer.
// Latency  : n/a (definitions only).
// Backpress: n/a (definitions only).
//
// State encodings and the legal channel-count range live here so that the top
// and any future siblings agree on them.
package demux_tdm_1xn_pkg;

    // Legal range of N_CH; checked at elaboration by the top.
    localparam int N_CH_MIN = 2;
    localparam int N_CH_MAX = 16;

    // ST_PAR is only reachable when PARITY_CHECK_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

endpackage

// File: rtl/demux_1xn_dec.sv
// Purpose  : one-hot write-enable decoder, CW-bit slot index to N enables.
// Latency  : combinational.
// Backpress: none; o_en is all-zero whenever i_stb is low.
//
// Ports: i_idx slot index, i_stb write strobe, o_en one-hot enables.
module demux_1xn_dec #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [W-1:0] i_idx,
    input  logic         i_stb,
    output logic [N-1:0] o_en
);

    always_comb begin
        o_en = '0;
        for (int k = 0; k < N; k++) begin
            if (i_stb && (i_idx == W'(k))) begin
                o_en[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_tdm_1xn.sv
// Purpose  : bit-per-slot TDM receive demux; steers serial bits into N_CH slots.
// Latency  : ch_out/frame_done update one cycle after the last beat of a frame.
// Backpress: none; in_valid low stalls the frame indefinitely, all state held.
//
// Ports: clk/rst_n (async active-low); in_bit/in_valid/in_sof serial side;
//        ch_out (bit k = slot k of last good frame), frame_done and sync_err
//        one-cycle pulses, active_ch = slot the next valid beat lands in.
// Build option: PARITY_CHECK_EN adds an even-parity beat after slot N_CH-1
//        and a par_err pulse output.
module demux_tdm_1xn
    import demux_tdm_1xn_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_bit,
    input  logic                      in_valid,
    input  logic                      in_sof,
    output logic [N_CH-1:0]           ch_out,
    output logic                      frame_done,
    output logic                      sync_err,
`ifdef PARITY_CHECK_EN
    output logic                      par_err,
`endif
    output logic [$clog2(N_CH)-1:0]   active_ch
);

    localparam int            CW   = $clog2(N_CH);
    localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
        $error("demux_tdm_1xn: N_CH out of legal range");
    end

    state_t          r_state,     w_state_nxt;
    logic [CW-1:0]   r_active_ch, w_active_nxt;
    logic [N_CH-1:0] r_staging;
    logic [N_CH-1:0] r_ch_out;
    logic            r_frame_done, w_done_nxt;
    logic            r_sync_err,   w_sync_nxt;
    logic            w_wr_stb;
    logic [CW-1:0]   w_wr_idx;
    logic [N_CH-1:0] w_wr_en;
    logic [N_CH-1:0] w_staging_nxt;
    logic            w_load_out;
`ifdef PARITY_CHECK_EN
    logic            r_par_err,    w_par_nxt;
`endif

    demux_1xn_dec #(
        .N (N_CH),
        .W (CW)
    ) u_dec (
        .i_idx (w_wr_idx),
        .i_stb (w_wr_stb),
        .o_en  (w_wr_en)
    );

    // Staging with this cycle's bit merged in; on the last data beat this is
    // the complete frame, so ch_out can load it on the same edge.
    assign w_staging_nxt = (r_staging & ~w_wr_en) | ({N_CH{in_bit}} & w_wr_en);

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active_ch;
        w_wr_stb     = 1'b0;
        w_wr_idx     = r_active_ch;
        w_load_out   = 1'b0;
        w_done_nxt   = 1'b0;
        w_sync_nxt   = 1'b0;
`ifdef PARITY_CHECK_EN
        w_par_nxt    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                // Beats without sof are silently dropped while unsynchronised.
                if (in_valid && in_sof) begin
                    w_wr_stb     = 1'b1;
                    w_wr_idx     = '0;
                    w_active_nxt = CW'(1);
                    w_state_nxt  = ST_RECV;
                end
            end
            ST_RECV: begin
                if (in_valid && in_sof) begin
                    // Early sof: drop the partial frame, restart at slot 0.
                    w_sync_nxt   = 1'b1;
                    w_wr_stb     = 1'b1;
                    w_wr_idx     = '0;
                    w_active_nxt = CW'(1);
                end else if (in_valid) begin
                    w_wr_stb = 1'b1;
                    if (r_active_ch == LAST) begin
                        w_active_nxt = '0;
`ifdef PARITY_CHECK_EN
                        w_state_nxt  = ST_PAR;
`else
                        w_state_nxt  = ST_IDLE;
                        w_load_out   = 1'b1;
                        w_done_nxt   = 1'b1;
`endif
                    end else begin
                        w_active_nxt = r_active_ch + 1'b1;
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            ST_PAR: begin
                if (in_valid && in_sof) begin
                    w_sync_nxt   = 1'b1;
                    w_wr_stb     = 1'b1;
                    w_wr_idx     = '0;
                    w_active_nxt = CW'(1);
                    w_state_nxt  = ST_RECV;
                end else if (in_valid) begin
                    w_state_nxt = ST_IDLE;
                    // Even parity: data ones plus parity bit must be even.
                    if ((^r_staging ^ in_bit) == 1'b0) begin
                        w_load_out = 1'b1;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_par_nxt  = 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt  = ST_IDLE;
                w_active_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_active_ch  <= '0;
            r_staging    <= '0;
            r_ch_out     <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_par_err    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_active_ch  <= w_active_nxt;
            r_staging    <= w_staging_nxt;
            r_frame_done <= w_done_nxt;
            r_sync_err   <= w_sync_nxt;
`ifdef PARITY_CHECK_EN
            r_par_err    <= w_par_nxt;
`endif
            if (w_load_out) begin
                r_ch_out <= w_staging_nxt;
            end
        end
    end

    assign ch_out     = r_ch_out;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;
    assign active_ch  = r_active_ch;
`ifdef PARITY_CHECK_EN
    assign par_err    = r_par_err;
`endif

endmodule

// File: tb/tb_demux_tdm_1xn.sv
// Purpose  : directed self-checking bench for demux_tdm_1xn with N_CH=4.
// Latency  : expects outputs one cycle after the last beat of each frame.
// Backpress: exercises in_valid stalls mid-frame.
module tb_demux_tdm_1xn;

    logic       clk;
    logic       rst_n;
    logic       in_bit;
    logic       in_valid;
    logic       in_sof;
    logic [3:0] ch_out;
    logic       frame_done;
    logic       sync_err;
    logic [1:0] active_ch;
`ifdef PARITY_CHECK_EN
    logic       par_err;
`endif

    int checks   = 0;
    int failures = 0;

    demux_tdm_1xn #(.N_CH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .ch_out     (ch_out),
        .frame_done (frame_done),
        .sync_err   (sync_err),
`ifdef PARITY_CHECK_EN
        .par_err    (par_err),
`endif
        .active_ch  (active_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat, let the DUT take it, then settle past the edge.
    task automatic drive(input logic v, input logic s, input logic b);
        in_valid = v;
        in_sof   = s;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_bit   = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ch_out", 16'(ch_out), 16'h0);
        chk("rst_done",   16'(frame_done), 16'h0);
        chk("rst_sync",   16'(sync_err), 16'h0);
        chk("rst_active", 16'(active_ch), 16'h0);
        rst_n = 1'b1;
        drive(0, 0, 0);

`ifndef PARITY_CHECK_EN
        // Basic frame 1,0,1,1 -> 4'b1101.
        drive(1, 1, 1);
        chk("a_active1", 16'(active_ch), 16'h1);
        drive(1, 0, 0);
        chk("a_active2", 16'(active_ch), 16'h2);
        drive(1, 0, 1);
        chk("a_active3", 16'(active_ch), 16'h3);
        chk("a_nodone",  16'(frame_done), 16'h0);
        drive(1, 0, 1);
        chk("a_ch_out",  16'(ch_out), 16'hD);
        chk("a_done",    16'(frame_done), 16'h1);
        chk("a_active0", 16'(active_ch), 16'h0);
        drive(0, 0, 0);
        chk("a_done_pulse", 16'(frame_done), 16'h0);
        chk("a_hold",    16'(ch_out), 16'hD);

        // Same frame with a 3-cycle stall after slot 1.
        drive(1, 1, 1);
        drive(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1);
            chk("b_stall_active", 16'(active_ch), 16'h2);
            chk("b_stall_done",   16'(frame_done), 16'h0);
        end
        drive(1, 0, 1);
        drive(1, 0, 1);
        chk("b_ch_out", 16'(ch_out), 16'hD);
        chk("b_done",   16'(frame_done), 16'h1);

        // Back-to-back frames 1,1,0,0 then 0,1,1,0.
        drive(1, 1, 1);
        chk("c_done_gap", 16'(frame_done), 16'h0);
        drive(1, 0, 1);
        drive(1, 0, 0);
        drive(1, 0, 0);
        chk("c_ch_out1", 16'(ch_out), 16'h3);
        chk("c_done1",   16'(frame_done), 16'h1);
        drive(1, 1, 0);
        chk("c_done1_end", 16'(frame_done), 16'h0);
        chk("c_active1",   16'(active_ch), 16'h1);
        chk("c_hold1",     16'(ch_out), 16'h3);
        drive(1, 0, 1);
        drive(1, 0, 1);
        drive(1, 0, 0);
        chk("c_ch_out2", 16'(ch_out), 16'h6);
        chk("c_done2",   16'(frame_done), 16'h1);
        drive(0, 0, 0);
        chk("c_done2_end", 16'(frame_done), 16'h0);

        // Early sof: sof,1,1 then sof with 0 followed by 1,1,1 -> 4'b1110.
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 0, 1);
        chk("d_active3", 16'(active_ch), 16'h3);
        drive(1, 1, 0);
        chk("d_sync",    16'(sync_err), 16'h1);
        chk("d_active1", 16'(active_ch), 16'h1);
        chk("d_hold",    16'(ch_out), 16'h6);
        chk("d_nodone",  16'(frame_done), 16'h0);
        drive(1, 0, 1);
        chk("d_sync_pulse", 16'(sync_err), 16'h0);
        drive(1, 0, 1);
        chk("d_hold2",   16'(ch_out), 16'h6);
        drive(1, 0, 1);
        chk("d_ch_out",  16'(ch_out), 16'hE);
        chk("d_done",    16'(frame_done), 16'h1);
        chk("d_nosync",  16'(sync_err), 16'h0);

        // Beat without sof in IDLE is ignored with no error.
        drive(1, 0, 1);
        chk("e_idle_active", 16'(active_ch), 16'h0);
        chk("e_idle_sync",   16'(sync_err), 16'h0);
        chk("e_idle_done",   16'(frame_done), 16'h0);

        // Reset asserted during slot 2 of a frame.
        drive(1, 1, 1);
        drive(1, 0, 0);
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_bit   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_rst_ch_out", 16'(ch_out), 16'h0);
        chk("f_rst_active", 16'(active_ch), 16'h0);
        chk("f_rst_done",   16'(frame_done), 16'h0);
        chk("f_rst_sync",   16'(sync_err), 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 1);
        drive(1, 0, 1);
        chk("f_ignore_active", 16'(active_ch), 16'h0);
        chk("f_ignore_ch_out", 16'(ch_out), 16'h0);
        chk("f_ignore_done",   16'(frame_done), 16'h0);
        drive(1, 1, 1);
        drive(1, 0, 0);
        drive(1, 0, 1);
        drive(1, 0, 1);
        chk("f_ch_out", 16'(ch_out), 16'hD);
        chk("f_done",   16'(frame_done), 16'h1);
`else
        // Frame 1,1,0,0 with parity 0 -> 4'b0011.
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 0, 0);
        drive(1, 0, 0);
        chk("p_wait_done", 16'(frame_done), 16'h0);
        chk("p_wait_ch",   16'(ch_out), 16'h0);
        drive(1, 0, 0);
        chk("p_ch_out0", 16'(ch_out), 16'h3);
        chk("p_done0",   16'(frame_done), 16'h1);
        chk("p_perr0",   16'(par_err), 16'h0);
        // Bits 1,0,1,1 with bad parity 0.
        drive(1, 1, 1);
        drive(1, 0, 0);
        drive(1, 0, 1);
        drive(1, 0, 1);
        drive(1, 0, 0);
        chk("p_bad_perr", 16'(par_err), 16'h1);
        chk("p_bad_done", 16'(frame_done), 16'h0);
        chk("p_bad_hold", 16'(ch_out), 16'h3);
        // Same bits with good parity 1.
        drive(1, 1, 1);
        chk("p_perr_pulse", 16'(par_err), 16'h0);
        drive(1, 0, 0);
        drive(1, 0, 1);
        drive(1, 0, 1);
        drive(1, 0, 1);
        chk("p_good_ch",   16'(ch_out), 16'hD);
        chk("p_good_done", 16'(frame_done), 16'h1);
        chk("p_good_perr", 16'(par_err), 16'h0);
        // sof on the parity beat is an early sof.
        drive(1, 1, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(1, 1, 1);
        chk("p_sof_sync",   16'(sync_err), 16'h1);
        chk("p_sof_active", 16'(active_ch), 16'h1);
        chk("p_sof_hold",   16'(ch_out), 16'hD);
`endif

        drive(0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
